// File: rtl/qpix_dac_pkg.sv
// Shared definitions for the MCP4911 write sequencer: FSM states, command-word
// bit positions and the request FIFO entry layout.
package qpix_dac_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_ISSUE,
    S_WAIT,
    S_DRAIN,
    S_STEP
  } state_t;

  // MCP4911 command word bit positions
  localparam int unsigned BIT_WRITE    = 15;
  localparam int unsigned BIT_BUF      = 14;
  localparam int unsigned BIT_GA_N     = 13;
  localparam int unsigned BIT_SHDN_N   = 12;
  localparam int unsigned BIT_DATA_MSB = 11;

  // FIFO entry = {code, buf, ga_n, shdn_n}
  localparam int unsigned ENT_SHDN_N   = 0;
  localparam int unsigned ENT_GA_N     = 1;
  localparam int unsigned ENT_BUF      = 2;
  localparam int unsigned ENT_CODE_LSB = 3;
  localparam int unsigned ENT_CFG_BITS = 3;

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with full/empty flags; synchronous reset flushes contents.
module sync_fifo #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] wdata,
  input  logic             pop,
  output logic [WIDTH-1:0] rdata,
  output logic             full,
  output logic             empty
);

  localparam int unsigned AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0]      wptr;
  logic [AW:0]      rptr;
  logic             do_push;
  logic             do_pop;

  assign do_push = push && !full;
  assign do_pop  = pop && !empty;

  always_ff @(posedge clk) begin
    if (rst) begin
      wptr <= '0;
      rptr <= '0;
    end else begin
      if (do_push) wptr <= wptr + 1'b1;
      if (do_pop)  rptr <= rptr + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wptr[AW-1:0]] <= wdata;
  end

  assign rdata = mem[rptr[AW-1:0]];
  assign empty = (wptr == rptr);
  assign full  = (wptr[AW] != rptr[AW]) && (wptr[AW-1:0] == rptr[AW-1:0]);

endmodule

// File: rtl/dac_write_sequencer.sv
// Buffers DAC setpoint requests and issues MCP4911 write words to the SPI driver.
// Optional feature macro: DAC_RAMP_EN (slew-limited approach to each target).
module dac_write_sequencer
  import qpix_dac_pkg::*;
#(
  parameter int unsigned DAC_BITS       = 10,
  parameter int unsigned SPI_LENGTH     = 16,
  parameter int unsigned FIFO_DEPTH     = 4,
  parameter int unsigned TIMEOUT_CYCLES = 4096,
  parameter int unsigned RAMP_STEP      = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic [DAC_BITS-1:0]   req_code,
  input  logic                  req_buf,
  input  logic                  req_ga_n,
  input  logic                  req_shdn_n,
  output logic                  spi_new_reg,
  output logic [SPI_LENGTH-1:0] spi_data,
  input  logic                  spi_done,
  input  logic                  err_clr,
  output logic                  busy,
  output logic                  fifo_full,
  output logic                  timeout_err,
  output logic [DAC_BITS-1:0]   cur_code
);

  localparam int unsigned EW = DAC_BITS + ENT_CFG_BITS;
  localparam int unsigned CW = $clog2(TIMEOUT_CYCLES);

  if (DAC_BITS < 8 || DAC_BITS > 12) begin : g_bad_dac_bits
    $error("DAC_BITS must be 8..12");
  end
  if (SPI_LENGTH < 16) begin : g_bad_spi_length
    $error("SPI_LENGTH must be at least 16");
  end
  if (FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_bad_depth
    $error("FIFO_DEPTH must be a power of 2, at least 2");
  end
  if (TIMEOUT_CYCLES < 2) begin : g_bad_timeout
    $error("TIMEOUT_CYCLES must be at least 2");
  end
  if (RAMP_STEP < 1) begin : g_bad_ramp_step
    $error("RAMP_STEP must be at least 1");
  end

  state_t                  state;
  state_t                  state_next;
  logic                    pop;
  logic                    load;
  logic                    commit;
  logic                    tmo;
  logic                    fifo_empty;
  logic [EW-1:0]           head;
  logic [DAC_BITS-1:0]     head_code;
  logic [ENT_CFG_BITS-1:0] head_cfg;
  logic [DAC_BITS-1:0]     next_code;
  logic [ENT_CFG_BITS-1:0] next_cfg;
  logic [DAC_BITS-1:0]     wr_code;
  logic [CW-1:0]           cnt;
  logic                    timeout_hit;

  assign req_ready = !fifo_full && !rst;

  sync_fifo #(
    .WIDTH (EW),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (req_valid && req_ready),
    .wdata ({req_code, req_buf, req_ga_n, req_shdn_n}),
    .pop   (pop),
    .rdata (head),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  assign head_code = head[ENT_CODE_LSB +: DAC_BITS];
  assign head_cfg  = head[ENT_CFG_BITS-1:0];

  function automatic logic [SPI_LENGTH-1:0] make_word(
    input logic [DAC_BITS-1:0]     code,
    input logic [ENT_CFG_BITS-1:0] cfg
  );
    logic [SPI_LENGTH-1:0] w;
    w                        = '0;
    w[BIT_WRITE]             = 1'b0;
    w[BIT_BUF]               = cfg[ENT_BUF];
    w[BIT_GA_N]              = cfg[ENT_GA_N];
    w[BIT_SHDN_N]            = cfg[ENT_SHDN_N];
    w[BIT_DATA_MSB -: DAC_BITS] = code;
    return w;
  endfunction

`ifdef DAC_RAMP_EN
  logic [DAC_BITS-1:0]     tgt_q;
  logic [ENT_CFG_BITS-1:0] cfg_q;
  logic [DAC_BITS-1:0]     ramp_tgt;
  logic signed [DAC_BITS:0] diff;
  logic signed [DAC_BITS:0] step_lim;

  // First write of an entry steps from the FIFO head; later ones from the held target.
  always_comb begin
    ramp_tgt = (state == S_IDLE) ? head_code : tgt_q;
    next_cfg = (state == S_IDLE) ? head_cfg : cfg_q;
    diff     = $signed({1'b0, ramp_tgt}) - $signed({1'b0, cur_code});
    step_lim = $signed((DAC_BITS + 1)'(RAMP_STEP));
    if (diff > step_lim)       next_code = cur_code + DAC_BITS'(RAMP_STEP);
    else if (diff < -step_lim) next_code = cur_code - DAC_BITS'(RAMP_STEP);
    else                       next_code = ramp_tgt;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      tgt_q <= '0;
      cfg_q <= '0;
    end else if (pop) begin
      tgt_q <= head_code;
      cfg_q <= head_cfg;
    end
  end
`else
  assign next_code = head_code;
  assign next_cfg  = head_cfg;
`endif

  assign timeout_hit = (cnt == CW'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge clk) begin
    if (rst) state <= S_IDLE;
    else     state <= state_next;
  end

  always_comb begin
    state_next = state;
    pop        = 1'b0;
    load       = 1'b0;
    commit     = 1'b0;
    tmo        = 1'b0;
    case (state)
      S_IDLE: begin
        if (!fifo_empty) begin
          pop        = 1'b1;
          load       = 1'b1;
          state_next = S_ISSUE;
        end
      end
      S_ISSUE: state_next = S_WAIT;
      S_WAIT: begin
        if (timeout_hit) begin
          tmo        = 1'b1;
          state_next = S_IDLE;
        end else if (spi_done) begin
          state_next = S_DRAIN;
        end
      end
      S_DRAIN: begin
        if (timeout_hit) begin
          tmo        = 1'b1;
          state_next = S_IDLE;
        end else if (!spi_done) begin
          commit     = 1'b1;
`ifdef DAC_RAMP_EN
          state_next = (wr_code == tgt_q) ? S_IDLE : S_STEP;
`else
          state_next = S_IDLE;
`endif
        end
      end
`ifdef DAC_RAMP_EN
      S_STEP: begin
        load       = 1'b1;
        state_next = S_ISSUE;
      end
`endif
      default: state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      spi_data    <= '0;
      wr_code     <= '0;
      cur_code    <= '0;
      cnt         <= '0;
      timeout_err <= 1'b0;
    end else begin
      if (load) begin
        spi_data <= make_word(next_code, next_cfg);
        wr_code  <= next_code;
        cnt      <= '0;
      end else if (state == S_WAIT || state == S_DRAIN) begin
        cnt <= cnt + CW'(1);
      end
      if (commit) cur_code <= wr_code;
      if (tmo)          timeout_err <= 1'b1;
      else if (err_clr) timeout_err <= 1'b0;
    end
  end

  assign spi_new_reg = (state == S_ISSUE);
  assign busy        = (state != S_IDLE) || !fifo_empty;

endmodule

// File: tb/tb_dac_write_sequencer.sv
// Directed self-checking bench for dac_write_sequencer (default build, or the
// ramp scenario when DAC_RAMP_EN is defined).
module tb_dac_write_sequencer;

  localparam int unsigned DAC_BITS = 10;

  logic                clk = 1'b0;
  logic                rst = 1'b1;
  logic                req_valid = 1'b0;
  logic                req_ready;
  logic [DAC_BITS-1:0] req_code = '0;
  logic                req_buf = 1'b0;
  logic                req_ga_n = 1'b0;
  logic                req_shdn_n = 1'b0;
  logic                spi_new_reg;
  logic [15:0]         spi_data;
  logic                spi_done = 1'b0;
  logic                err_clr = 1'b0;
  logic                busy;
  logic                fifo_full;
  logic                timeout_err;
  logic [DAC_BITS-1:0] cur_code;

  int checks = 0;
  int errors = 0;

  dac_write_sequencer #(
    .DAC_BITS       (DAC_BITS),
    .SPI_LENGTH     (16),
    .FIFO_DEPTH     (4),
    .TIMEOUT_CYCLES (64),
    .RAMP_STEP      (8)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .req_valid   (req_valid),
    .req_ready   (req_ready),
    .req_code    (req_code),
    .req_buf     (req_buf),
    .req_ga_n    (req_ga_n),
    .req_shdn_n  (req_shdn_n),
    .spi_new_reg (spi_new_reg),
    .spi_data    (spi_data),
    .spi_done    (spi_done),
    .err_clr     (err_clr),
    .busy        (busy),
    .fifo_full   (fifo_full),
    .timeout_err (timeout_err),
    .cur_code    (cur_code)
  );

  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic set_req(input logic [9:0] code, input logic b, input logic g, input logic s);
    req_code   = code;
    req_buf    = b;
    req_ga_n   = g;
    req_shdn_n = s;
    req_valid  = 1'b1;
  endtask

  task automatic push(input logic [9:0] code, input logic b, input logic g, input logic s);
    set_req(code, b, g, s);
    tick();
    req_valid = 1'b0;
  endtask

  task automatic expect_issue(input logic [15:0] word, input string tag);
    int k = 0;
    while (spi_new_reg !== 1'b1 && k < 20) begin
      tick();
      k++;
    end
    check({tag, " issue"}, {31'd0, spi_new_reg}, 32'd1);
    check({tag, " word"}, {16'd0, spi_data}, {16'd0, word});
  endtask

  // Called once the FSM has left S_ISSUE; runs a 3-cycle done pulse.
  task automatic finish_write(input logic [15:0] word, input logic [9:0] code, input string tag);
    logic changed = 1'b0;
    logic reissue = 1'b0;
    spi_done = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      if (spi_data !== word) changed = 1'b1;
      if (spi_new_reg !== 1'b0) reissue = 1'b1;
    end
    spi_done = 1'b0;
    tick();
    if (spi_data !== word) changed = 1'b1;
    check({tag, " data stable"}, {31'd0, changed}, 32'd0);
    check({tag, " no pulse in done"}, {31'd0, reissue}, 32'd0);
    check({tag, " cur_code"}, {22'd0, cur_code}, {22'd0, code});
  endtask

  initial begin
    repeat (2) tick();
    rst = 1'b0;
    #1;
    check("reset new_reg", {31'd0, spi_new_reg}, 32'd0);
    check("reset spi_data", {16'd0, spi_data}, 32'd0);
    check("reset cur_code", {22'd0, cur_code}, 32'd0);
    check("reset timeout_err", {31'd0, timeout_err}, 32'd0);
    check("reset busy", {31'd0, busy}, 32'd0);
    check("reset ready", {31'd0, req_ready}, 32'd1);

`ifndef DAC_RAMP_EN
    // Single request: accepted at E0, pulse E1..E2
    push(10'h2A5, 1'b0, 1'b1, 1'b1);
    check("single no pulse at E0", {31'd0, spi_new_reg}, 32'd0);
    check("single busy", {31'd0, busy}, 32'd1);
    tick();
    check("single pulse at E1", {31'd0, spi_new_reg}, 32'd1);
    check("single word", {16'd0, spi_data}, 32'h3A94);
    tick();
    check("single pulse ends", {31'd0, spi_new_reg}, 32'd0);
    finish_write(16'h3A94, 10'h2A5, "single");
    check("single idle", {31'd0, busy}, 32'd0);

    // done in S_IDLE is ignored
    spi_done = 1'b1;
    repeat (2) tick();
    check("idle done busy", {31'd0, busy}, 32'd0);
    check("idle done cur", {22'd0, cur_code}, 32'h2A5);
    spi_done = 1'b0;
    tick();

    // Back-to-back with driver busy on X
    push(10'h100, 1'b0, 1'b1, 1'b1);
    expect_issue(16'h3400, "X");
    tick();
    set_req(10'h001, 1'b1, 1'b1, 1'b1); check("bb ready 1", {31'd0, req_ready}, 32'd1); tick();
    set_req(10'h3FF, 1'b0, 1'b0, 1'b0); check("bb ready 2", {31'd0, req_ready}, 32'd1); tick();
    set_req(10'h155, 1'b1, 1'b0, 1'b0); check("bb ready 3", {31'd0, req_ready}, 32'd1); tick();
    set_req(10'h0AA, 1'b0, 1'b1, 1'b0); check("bb ready 4", {31'd0, req_ready}, 32'd1); tick();
    set_req(10'h200, 1'b0, 1'b0, 1'b1);
    check("bb ready after 4th", {31'd0, req_ready}, 32'd0);
    check("bb full", {31'd0, fifo_full}, 32'd1);
    finish_write(16'h3400, 10'h100, "X");
    tick();
    expect_issue(16'h7004, "E1");
    check("bb ready after pop", {31'd0, req_ready}, 32'd1);
    tick();
    req_valid = 1'b0;
    check("bb full after 5th", {31'd0, fifo_full}, 32'd1);
    finish_write(16'h7004, 10'h001, "E1");
    expect_issue(16'h0FFC, "E2"); tick(); finish_write(16'h0FFC, 10'h3FF, "E2");
    expect_issue(16'h4554, "E3"); tick(); finish_write(16'h4554, 10'h155, "E3");
    expect_issue(16'h22A8, "E4"); tick(); finish_write(16'h22A8, 10'h0AA, "E4");
    expect_issue(16'h1800, "E5"); tick(); finish_write(16'h1800, 10'h200, "E5");

    // Timeout: flag rises 64 cycles after leaving S_ISSUE
    push(10'h123, 1'b0, 1'b1, 1'b1);
    push(10'h0F0, 1'b0, 1'b1, 1'b1);
    expect_issue(16'h348C, "P");
    tick();
    repeat (63) tick();
    check("tmo not yet", {31'd0, timeout_err}, 32'd0);
    tick();
    check("tmo set", {31'd0, timeout_err}, 32'd1);
    check("tmo cur unchanged", {22'd0, cur_code}, 32'h200);
    tick();
    check("tmo next issued", {31'd0, spi_new_reg}, 32'd1);
    check("tmo next word", {16'd0, spi_data}, 32'h33C0);
    tick();
    finish_write(16'h33C0, 10'h0F0, "Q");

    // err_clr coincident with a new timeout
    err_clr = 1'b1; tick(); err_clr = 1'b0;
    check("err_clr clears", {31'd0, timeout_err}, 32'd0);
    push(10'h050, 1'b0, 1'b1, 1'b1);
    expect_issue(16'h3140, "R");
    tick();
    repeat (63) tick();
    check("tmo2 not yet", {31'd0, timeout_err}, 32'd0);
    err_clr = 1'b1; tick(); err_clr = 1'b0;
    check("tmo2 set wins", {31'd0, timeout_err}, 32'd1);
    check("tmo2 cur unchanged", {22'd0, cur_code}, 32'h0F0);
    tick();
    err_clr = 1'b1; tick(); err_clr = 1'b0;
    check("err_clr after tmo2", {31'd0, timeout_err}, 32'd0);
`else
    // Ramp from 0 to 0x014 in steps of 8
    push(10'h014, 1'b1, 1'b0, 1'b1);
    expect_issue(16'h5020, "R1"); tick(); finish_write(16'h5020, 10'h008, "R1");
    expect_issue(16'h5040, "R2"); tick(); finish_write(16'h5040, 10'h010, "R2");
    expect_issue(16'h5050, "R3"); tick(); finish_write(16'h5050, 10'h014, "R3");
    tick();
    check("ramp idle", {31'd0, busy}, 32'd0);
    check("ramp no extra", {31'd0, spi_new_reg}, 32'd0);
    // Zero diff still writes once
    push(10'h014, 1'b1, 1'b0, 1'b1);
    expect_issue(16'h5050, "R0"); tick(); finish_write(16'h5050, 10'h014, "R0");
`endif

    // Reset while in S_WAIT with two entries queued
    push(10'h111, 1'b0, 1'b1, 1'b1);
    set_req(10'h222, 1'b0, 1'b1, 1'b1);
    tick();
    check("rst test issue", {31'd0, spi_new_reg}, 32'd1);
    set_req(10'h333, 1'b0, 1'b1, 1'b1);
    tick();
    req_valid = 1'b0;
    check("rst test busy", {31'd0, busy}, 32'd1);
    rst = 1'b1;
    #1;
    check("ready low in rst", {31'd0, req_ready}, 32'd0);
    tick();
    rst = 1'b0;
    #1;
    check("post rst busy", {31'd0, busy}, 32'd0);
    check("post rst full", {31'd0, fifo_full}, 32'd0);
    check("post rst new_reg", {31'd0, spi_new_reg}, 32'd0);
    check("post rst cur", {22'd0, cur_code}, 32'd0);
    check("post rst data", {16'd0, spi_data}, 32'd0);
    begin
      int pulses = 0;
      for (int i = 0; i < 10; i++) begin
        tick();
        if (spi_new_reg === 1'b1) pulses++;
      end
      check("post rst no reissue", pulses, 32'd0);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/dac_write_sequencer.md
# dac_write_sequencer

Upstream command stage for the MCP4911 SPI driver. Accepts DAC setpoint requests over a valid/ready port, buffers them in a small FIFO and formats each one as a 16-bit MCP4911 write word. Issues each word to the SPI driver with a one-cycle `new_reg` pulse, holds the word stable until the driver's `done` completes, and detects a stalled driver with a timeout. Sits between the slow-control register file and the SPI driver; both blocks share `clk` and `rst`.

## Interface
Parameters:
- `DAC_BITS`, 10: DAC code width; legal range 8..12.
- `SPI_LENGTH`, 16: SPI word width; must equal the SPI driver's `spi_length`.
- `FIFO_DEPTH`, 4: request FIFO entries; power of 2, at least 2.
- `TIMEOUT_CYCLES`, 4096: maximum `clk` cycles from issue until `done` falls.
- `RAMP_STEP`, 8: maximum code change per write; used only under `DAC_RAMP_EN`.

Ports:
- `clk`  in  1  single clock.
- `rst`  in  1  synchronous reset, active-high.
- `req_valid`  in  1  request offered.
- `req_ready`  out  1  equals `!fifo_full && !rst`.
- `req_code`  in  `DAC_BITS`  target DAC code.
- `req_buf`, `req_ga_n`, `req_shdn_n`  in  1 each  MCP4911 config bits.
- `spi_new_reg`  out  1  one-cycle issue pulse to the driver.
- `spi_data`  out  `SPI_LENGTH`  command word; held stable from issue until `done` falls.
- `spi_done`  in  1  driver `done`; high for several cycles.
- `err_clr`  in  1  clears `timeout_err`.
- `busy`  out  1  high when not in S_IDLE or when the FIFO is non-empty.
- `fifo_full`  out  1  FIFO full flag.
- `timeout_err`  out  1  sticky timeout flag.
- `cur_code`  out  `DAC_BITS`  last code actually written.

## Operation
- Word format: `{1'b0, buf, ga_n, shdn_n, code, zeros}`, with `code` left-justified in bits [11 -: DAC_BITS] and the low bits zero.
- FIFO: a push occurs when `req_valid && req_ready`. Push and pop in the same cycle are legal when the FIFO is neither full nor empty. There is no push-through when full. Entry = {code, buf, ga_n, shdn_n}.
- States:
  - S_IDLE: if the FIFO is non-empty, pop the head, register `spi_data`, set `spi_new_reg`, go to S_ISSUE.
  - S_ISSUE: lasts one cycle, `spi_new_reg`=1. Go to S_WAIT.
  - S_WAIT: wait for `spi_done`=1, then go to S_DRAIN.
  - S_DRAIN: wait for `spi_done`=0, then update `cur_code`. Go to S_IDLE, or under ramp go to S_STEP if the target has not been reached.
  - S_STEP: compute the next step word and go to S_ISSUE.
- Timeout counter: cleared on entry to S_ISSUE and counts in S_WAIT and S_DRAIN. On reaching `TIMEOUT_CYCLES - 1`:
  - set `timeout_err`;
  - discard the current entry without updating `cur_code`;
  - abandon any remaining ramp;
  - go to S_IDLE.
- `timeout_err`: if a set and `err_clr` occur in the same cycle, the set wins.
- Reset values: `spi_new_reg`=0, `spi_data`=0, `cur_code`=0, `timeout_err`=0, `busy`=0, FIFO empty, state S_IDLE.
- Reset mid-transfer: the FIFO is flushed and no word is reissued; the driver is reset by the same `rst`.

## Timing
- If a request is accepted at edge E0, the pop occurs at E1 and `spi_new_reg` is high in cycle E1..E2 only. This assumes S_IDLE and an empty FIFO before E0.
- `spi_data` must not change between E1 and the cycle after `spi_done` falls.
- Back-to-back requests: the next `spi_new_reg` comes no earlier than 1 cycle after the S_DRAIN exit. The driver therefore always sees the pulse while it is idle.
- A `spi_done` pulse arriving in S_IDLE or S_ISSUE is ignored.

## Configuration
- `DAC_RAMP_EN` defined:
  - Each FIFO entry is approached from `cur_code` in writes of at most `RAMP_STEP` codes.
  - Diff is computed as signed, `DAC_BITS+1` bits; step = sign · min(|diff|, `RAMP_STEP`). The result cannot leave 0..2^DAC_BITS−1.
  - Every intermediate word carries the entry's config bits.
  - A diff of 0 still produces one write.
- `DAC_RAMP_EN` undefined: one write per entry, directly to the target. S_STEP and the ramp arithmetic are not compiled.

## Structure
- Package `qpix_dac_pkg` holds:
  - the state encoding;
  - MCP4911 bit positions (WRITE=15, BUF=14, GA_N=13, SHDN_N=12, DATA_MSB=11);
  - the FIFO entry layout.
- Sub-module `sync_fifo` is parameterised by width and depth, with full/empty flags and a synchronous reset that flushes it.

## Test plan
- Reset, then a single request code=0x2A5, buf=0, ga_n=1, shdn_n=1 → one `spi_new_reg` pulse with `spi_data`=0x3A94, and `cur_code`=0x2A5 after `done` falls.
- 5 requests pushed back-to-back with `FIFO_DEPTH`=4 and the driver busy → `req_ready`=0 after the 4th accept; all words are issued in order and each `spi_data` is stable through its `done`.
- Driver model never asserts `spi_done`, `TIMEOUT_CYCLES`=64 → `timeout_err`=1 at cycle 64 after issue, `cur_code` unchanged, next FIFO entry issued.
- `err_clr` asserted in the same cycle as a new timeout → `timeout_err` stays 1.
- `DAC_RAMP_EN`, `cur_code`=0, request 0x014, `RAMP_STEP`=8 → writes of 0x008, 0x010, 0x014, then S_IDLE.
- `rst` asserted in S_WAIT with 2 entries queued → FIFO empty, `spi_new_reg`=0, `cur_code`=0, no further issues.
